// File: rtl/fetch_decode_stage.sv
// Instruction fetch stage with IF/ID pipeline register and immediate pre-decode.
// Keeps one imem request in flight; a hold buffer parks a word that arrives while decode is stalled.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [2:0]  id_imm_fmt,
    output logic [20:0] id_imm
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        discard, discard_next;
    logic [31:0] hold_pc, hold_pc_next;
    logic [31:0] hold_instr, hold_instr_next;
    logic        id_valid_next;
    logic [31:0] id_pc_next, id_instr_next;
    logic [2:0]  id_imm_fmt_next;
    logic [20:0] id_imm_next;
    logic        load_id;
    logic [31:0] load_pc, load_instr;

    // Returns {fmt, raw immediate}; the immediate generator does the sign extension and shift.
    function automatic logic [23:0] predecode(input logic [31:0] instr);
        logic [23:0] result;
        result = 24'h0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                result = {3'b001, 9'b0, instr[31:20]};
            7'b0100011:
                result = {3'b001, 9'b0, instr[31:25], instr[11:7]};
            7'b1100011:
                result = {3'b011, 9'b0, instr[31], instr[7], instr[30:25], instr[11:8]};
            7'b0110111, 7'b0010111:
                result = {3'b100, 1'b0, instr[31:12]};
            default:
                result = 24'h0;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            discard    <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
            id_valid   <= 1'b0;
            id_pc      <= 32'h0;
            id_instr   <= 32'h0;
            id_imm_fmt <= 3'b000;
            id_imm     <= 21'h0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            discard    <= discard_next;
            hold_pc    <= hold_pc_next;
            hold_instr <= hold_instr_next;
            id_valid   <= id_valid_next;
            id_pc      <= id_pc_next;
            id_instr   <= id_instr_next;
            id_imm_fmt <= id_imm_fmt_next;
            id_imm     <= id_imm_next;
        end
    end

    // Redirect overrides everything; a request already accepted must have its word discarded later.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        discard_next    = discard;
        hold_pc_next    = hold_pc;
        hold_instr_next = hold_instr;
        id_valid_next   = id_valid & stall;
        id_pc_next      = id_pc;
        id_instr_next   = id_instr;
        id_imm_fmt_next = id_imm_fmt;
        id_imm_next     = id_imm;
        load_id         = 1'b0;
        load_pc         = pc;
        load_instr      = imem_rsp_data;

        if (redirect_valid) begin
            pc_next       = redirect_pc & ~32'h3;
            id_valid_next = 1'b0;
            if ((state == S_REQ && imem_req_ready) || (state == S_WAIT && !imem_rsp_valid)) begin
                discard_next = 1'b1;
                state_next   = S_WAIT;
            end else begin
                discard_next = 1'b0;
                state_next   = S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready)
                        state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (discard) begin
                            discard_next = 1'b0;
                            state_next   = S_REQ;
                        end else if (!id_valid || !stall) begin
                            load_id    = 1'b1;
                            pc_next    = pc + 32'd4;
                            state_next = S_REQ;
                        end else begin
                            hold_pc_next    = pc;
                            hold_instr_next = imem_rsp_data;
                            pc_next         = pc + 32'd4;
                            state_next      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        load_id    = 1'b1;
                        load_pc    = hold_pc;
                        load_instr = hold_instr;
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end

        if (load_id) begin
            id_valid_next = 1'b1;
            id_pc_next    = load_pc;
            id_instr_next = load_instr;
            {id_imm_fmt_next, id_imm_next} = predecode(load_instr);
        end
    end

    always_comb begin
        imem_req_valid = (state == S_REQ) && !rst;
        imem_req_addr  = pc;
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a vector table for the streaming fetch/pre-decode path,
// then hand-written stall, redirect and mid-transaction reset sequences.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic [2:0]  id_imm_fmt;
    logic [20:0] id_imm;

    logic        req_valid_w, id_valid_w;
    logic [31:0] req_addr_w, id_pc_w, id_instr_w;
    logic [2:0]  id_imm_fmt_w;
    logic [20:0] id_imm_w;

    int  tests_run = 0;
    int  tests_failed = 0;
    logic auto_mem;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [20:0] imm;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    fetch_decode_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_imm_fmt(id_imm_fmt), .id_imm(id_imm)
    );

    // Second instance starts at the top of the address space to exercise PC wraparound.
    fetch_decode_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_w), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr_w),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid_w), .id_pc(id_pc_w), .id_instr(id_instr_w),
        .id_imm_fmt(id_imm_fmt_w), .id_imm(id_imm_w)
    );

    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'h00: return 32'hFFF00093;
            32'h04: return 32'h123450B7;
            32'h08: return 32'hFE000EE3;
            32'h0C: return 32'h00112223;
            32'h10: return 32'h00000033;
            32'h14: return 32'h0040006F;
            32'h18: return 32'h00812083;
            32'h1C: return 32'hABCDE517;
            32'h20: return 32'h00C08067;
            32'h24: return 32'h7FF00113;
            32'h28: return 32'h02A00193;
            default: return 32'h00000013;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One clock cycle; in auto mode the bench acts as a memory that answers one cycle after a handshake.
    task automatic applyStimulus();
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rsp_valid = hs;
            imem_rsp_data  = hs ? prog(a) : 32'h0;
        end
    endtask

    task automatic waitIdValid(output int cycles);
        cycles = 0;
        do begin
            applyStimulus();
            cycles++;
        end while (!id_valid && cycles < 10);
        if (!id_valid) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL id_valid timeout: got 0 after %0d cycles, expected 1", cycles);
        end
    endtask

    initial begin
        int cycles;

        vecs[0] = '{32'h00, 32'hFFF00093, 3'b001, 21'h000FFF};
        vecs[1] = '{32'h04, 32'h123450B7, 3'b100, 21'h012345};
        vecs[2] = '{32'h08, 32'hFE000EE3, 3'b011, 21'h000FFE};
        vecs[3] = '{32'h0C, 32'h00112223, 3'b001, 21'h000004};
        vecs[4] = '{32'h10, 32'h00000033, 3'b000, 21'h000000};
        vecs[5] = '{32'h14, 32'h0040006F, 3'b000, 21'h000000};
        vecs[6] = '{32'h18, 32'h00812083, 3'b001, 21'h000008};
        vecs[7] = '{32'h1C, 32'hABCDE517, 3'b100, 21'h0ABCDE};
        vecs[8] = '{32'h20, 32'h00C08067, 3'b001, 21'h00000C};
        vecs[9] = '{32'h24, 32'h7FF00113, 3'b001, 21'h0007FF};

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        auto_mem = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset id_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("reset id_pc", id_pc, 32'h0);
        checkOutput("reset id_instr", id_instr, 32'h0);
        checkOutput("reset id_imm_fmt", {29'b0, id_imm_fmt}, 32'd0);
        checkOutput("reset id_imm", {11'b0, id_imm}, 32'h0);
        checkOutput("reset req_valid", {31'b0, imem_req_valid}, 32'd0);

        rst = 1'b0;
        #1;
        checkOutput("first req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("first req_addr", imem_req_addr, 32'h0);
        checkOutput("wrap first req_addr", req_addr_w, 32'hFFFF_FFFC);

        for (int i = 0; i < 10; i++) begin
            waitIdValid(cycles);
            checkOutput($sformatf("vec%0d cycles", i), cycles, 32'd2);
            checkOutput($sformatf("vec%0d id_pc", i), id_pc, vecs[i].pc);
            checkOutput($sformatf("vec%0d id_instr", i), id_instr, vecs[i].instr);
            checkOutput($sformatf("vec%0d id_imm_fmt", i), {29'b0, id_imm_fmt}, {29'b0, vecs[i].fmt});
            checkOutput($sformatf("vec%0d id_imm", i), {11'b0, id_imm}, {11'b0, vecs[i].imm});
            if (i == 0) begin
                checkOutput("wrap id_pc", id_pc_w, 32'hFFFF_FFFC);
                checkOutput("wrap second req_addr", req_addr_w, 32'h0);
                checkOutput("wrap second req_valid", {31'b0, req_valid_w}, 32'd1);
            end
        end

        // Stall with a live instruction while the next word comes back.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("stall%0d id_valid", i), {31'b0, id_valid}, 32'd1);
            checkOutput($sformatf("stall%0d id_pc", i), id_pc, 32'h24);
            checkOutput($sformatf("stall%0d id_instr", i), id_instr, 32'h7FF00113);
        end
        checkOutput("hold req_valid", {31'b0, imem_req_valid}, 32'd0);
        stall = 1'b0;
        applyStimulus();
        checkOutput("unstall id_valid", {31'b0, id_valid}, 32'd1);
        checkOutput("unstall id_pc", id_pc, 32'h28);
        checkOutput("unstall id_instr", id_instr, 32'h02A00193);
        checkOutput("unstall id_imm", {11'b0, id_imm}, 32'h02A);
        checkOutput("unstall req_addr", imem_req_addr, 32'h2C);
        checkOutput("unstall req_valid", {31'b0, imem_req_valid}, 32'd1);

        // Redirect while waiting; the response that arrives later belongs to the old path.
        auto_mem = 1'b0;
        applyStimulus();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("redir req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("redir id_valid", {31'b0, id_valid}, 32'd0);
        applyStimulus();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h00000013;
        applyStimulus();
        imem_rsp_valid = 1'b0;
        checkOutput("dropped id_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("redir req_valid2", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("redir req_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;
        applyStimulus();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h123450B7;
        applyStimulus();
        imem_rsp_valid = 1'b0;
        checkOutput("redir id_valid2", {31'b0, id_valid}, 32'd1);
        checkOutput("redir id_pc", id_pc, 32'h100);
        checkOutput("redir id_imm_fmt", {29'b0, id_imm_fmt}, 32'd4);

        // Reset in the middle of an outstanding fetch.
        stall = 1'b1;
        applyStimulus();
        checkOutput("midwait id_valid", {31'b0, id_valid}, 32'd1);
        rst = 1'b1;
        applyStimulus();
        checkOutput("midrst id_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("midrst id_pc", id_pc, 32'h0);
        checkOutput("midrst id_instr", id_instr, 32'h0);
        checkOutput("midrst id_imm_fmt", {29'b0, id_imm_fmt}, 32'd0);
        checkOutput("midrst id_imm", {11'b0, id_imm}, 32'h0);
        checkOutput("midrst req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("postrst req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("postrst req_addr", imem_req_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
